// File: rtl/ws2812_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ws2812_pkg
// Description : Shared types and default timing for the WS2812 transmitter.
//               - state_t     : transmitter FSM states
//               - T*_DEF      : default timing in clk cycles (50 MHz clock)
//               - WORD_W      : bits per LED word
//               - grb_order() : reorders {R,G,B} into the strip's {G,R,B}
// Revision    : 1.0 - initial release
// ============================================================================
package ws2812_pkg;

   localparam int WORD_W   = 24;

   localparam int T0H_DEF  = 20;     // 400 ns high for a 0 bit
   localparam int T1H_DEF  = 40;     // 800 ns high for a 1 bit
   localparam int TBIT_DEF = 63;     // 1.26 us bit period
   localparam int TRST_DEF = 15000;  // 300 us latch low period

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      REQ     = 3'd1,
      LOAD    = 3'd2,
      SEND    = 3'd3,
      RST_LOW = 3'd4
   } state_t;

   function automatic logic [WORD_W-1:0] grb_order(input logic [WORD_W-1:0] rgb);
      return {rgb[15:8], rgb[23:16], rgb[7:0]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/ws2812_bit_gen.sv
`default_nettype none
// ============================================================================
// Module      : ws2812_bit_gen
// Description : Generates the NRZ high/low waveform of one WS2812 bit.
//               While en is held high the internal cycle counter runs
//               0..TBIT-1 and wraps, so consecutive bits follow without gaps;
//               dropping en clears the counter so the next bit starts at 0.
// Ports       : clk, rst  - clock, synchronous active-high reset
//               en        - high for every cycle of the bit stream
//               bit_val   - value of the bit currently being sent
//               level     - line level for this cycle
//               bit_end   - high in the final cycle of each bit
// Revision    : 1.0 - initial release
// ============================================================================
module ws2812_bit_gen
   import ws2812_pkg::*;
#(
   parameter int T0H  = T0H_DEF,   // requires TBIT > T1H > T0H > 0
   parameter int T1H  = T1H_DEF,
   parameter int TBIT = TBIT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic bit_val,
   output logic level,
   output logic bit_end
);

   localparam int CW = $clog2(TBIT);

   logic [CW-1:0] cyc;

   always_ff @(posedge clk) begin
      if (rst || !en || bit_end) begin
         cyc <= '0;
      end else begin
         cyc <= cyc + 1'b1;
      end
   end

   assign bit_end = en && (cyc == CW'(TBIT - 1));
   assign level   = en && (cyc < (bit_val ? CW'(T1H) : CW'(T0H)));

endmodule
`default_nettype wire

// File: rtl/ws2812_tx.sv
`default_nettype none
// ============================================================================
// Module      : ws2812_tx
// Description : WS2812 single-wire transmitter. Requests 24-bit words with a
//               one-cycle tx_done pulse, shifts each word out MSB first as
//               NRZ pulses, and holds the line low for TRST cycles after the
//               word flagged by data_valid (or after an abort).
// Ports       : clk, rst    - clock, synchronous active-high reset
//               data_ready  - frame enable; low aborts the current word
//               data_valid  - marks the word as last in the frame
//               RGB[23:0]   - word, captured in the cycle after tx_done
//               tx_done     - request/accept pulse for the next word
//               dout        - WS2812 data line
//               busy        - high in REQ, LOAD, SEND and RST_LOW
// Options     : WS2812_GRB_SWAP_EN - when defined, RGB {R,G,B} is sent as
//               {G,R,B}; otherwise RGB is sent unmodified.
// Revision    : 1.0 - initial release
// ============================================================================
module ws2812_tx
   import ws2812_pkg::*;
#(
   parameter int T0H  = T0H_DEF,
   parameter int T1H  = T1H_DEF,
   parameter int TBIT = TBIT_DEF,
   parameter int TRST = TRST_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              data_ready,
   input  logic              data_valid,
   input  logic [WORD_W-1:0] RGB,
   output logic              tx_done,
   output logic              dout,
   output logic              busy
);

   localparam int CW = $clog2(TRST + 1);

   state_t              state;
   state_t              state_nx;
   logic [WORD_W-1:0]   shift;
   logic [WORD_W-1:0]   load_word;
   logic [4:0]          bit_cnt;
   logic [CW-1:0]       cyc;
   logic                last;
   logic                send_en;
   logic                bit_level;
   logic                bit_end;

`ifdef WS2812_GRB_SWAP_EN
   assign load_word = grb_order(RGB);
`else
   assign load_word = RGB;
`endif

   // Derived straight from the state register so the bit generator's
   // outputs never loop back through the next-state logic.
   assign send_en = (state == SEND);

   ws2812_bit_gen #(
      .T0H  (T0H),
      .T1H  (T1H),
      .TBIT (TBIT)
   ) u_bit_gen (
      .clk     (clk),
      .rst     (rst),
      .en      (send_en),
      .bit_val (shift[WORD_W-1]),
      .level   (bit_level),
      .bit_end (bit_end)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      tx_done  = 1'b0;
      busy     = 1'b0;
      dout     = 1'b0;
      case (state)
         IDLE: begin
            if (data_ready) state_nx = REQ;
         end
         REQ: begin
            tx_done  = 1'b1;
            busy     = 1'b1;
            state_nx = data_ready ? LOAD : RST_LOW;
         end
         LOAD: begin
            busy     = 1'b1;
            state_nx = data_ready ? SEND : RST_LOW;
         end
         SEND: begin
            busy = 1'b1;
            dout = bit_level;
            if (!data_ready) begin
               state_nx = RST_LOW;
            end else if (bit_end && (bit_cnt == 5'd23)) begin
               state_nx = last ? RST_LOW : REQ;
            end
         end
         RST_LOW: begin
            busy = 1'b1;
            if (cyc == CW'(TRST - 1)) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // cyc is left at zero through LOAD and SEND, so RST_LOW always starts
   // counting from zero whichever state it is entered from.
   always_ff @(posedge clk) begin
      if (rst) begin
         shift   <= '0;
         bit_cnt <= '0;
         cyc     <= '0;
         last    <= 1'b0;
      end else begin
         case (state)
            LOAD: begin
               shift   <= load_word;
               last    <= data_valid;
               bit_cnt <= '0;
               cyc     <= '0;
            end
            SEND: begin
               if (bit_end) begin
                  shift   <= {shift[WORD_W-2:0], 1'b0};
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            RST_LOW: begin
               cyc <= cyc + 1'b1;
            end
            default: begin
               cyc <= '0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ws2812_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ws2812_tx
// Description : Self-checking bench for ws2812_tx using reduced timing
//               (T0H=2, T1H=4, TBIT=6, TRST=10). Expected line waveforms are
//               computed from the word, the bit timing and the word order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ws2812_tx;

   localparam int T0H      = 2;
   localparam int T1H      = 4;
   localparam int TBIT     = 6;
   localparam int TRST     = 10;
   localparam int WORD_CYC = 24 * TBIT;

   logic        clk        = 1'b0;
   logic        rst        = 1'b1;
   logic        data_ready = 1'b0;
   logic        data_valid = 1'b0;
   logic [23:0] rgb        = '0;
   logic        tx_done;
   logic        dout;
   logic        busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ws2812_tx #(
      .T0H  (T0H),
      .T1H  (T1H),
      .TBIT (TBIT),
      .TRST (TRST)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .data_ready (data_ready),
      .data_valid (data_valid),
      .RGB        (rgb),
      .tx_done    (tx_done),
      .dout       (dout),
      .busy       (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Order in which the word's bits appear on the line.
   function automatic logic [23:0] wire_order(input logic [23:0] w);
`ifdef WS2812_GRB_SWAP_EN
      return {w[15:8], w[23:16], w[7:0]};
`else
      return w;
`endif
   endfunction

   // Called at the falling edge of a tx_done cycle; returns at the falling
   // edge of the last cycle of the word.
   task automatic send_word(input logic [23:0] w, input logic lst, input string tag);
      logic [23:0] ex;
      logic [23:0] ob;
      logic        expd;
      int          werr;
      int          cerr;
      int          b;
      int          c;
      ex   = wire_order(w);
      ob   = '0;
      werr = 0;
      cerr = 0;
      rgb        = w;
      data_valid = lst;
      @(negedge clk);
      if (dout !== 1'b0 || tx_done !== 1'b0 || busy !== 1'b1) cerr++;
      for (int k = 0; k < WORD_CYC; k++) begin
         @(negedge clk);
         if (k == 0) begin
            rgb        = 24'($urandom);
            data_valid = 1'($urandom);
         end
         b    = k / TBIT;
         c    = k % TBIT;
         expd = (c < (ex[23-b] ? T1H : T0H));
         if (dout !== expd) werr++;
         if (c == T0H) ob[23-b] = dout;
         if (tx_done !== 1'b0 || busy !== 1'b1) cerr++;
      end
      check($sformatf("%s_wave", tag), werr, 0);
      check($sformatf("%s_bits", tag), ob, ex);
      check($sformatf("%s_ctl", tag), cerr, 0);
   endtask

   // Called at the falling edge of the first latch cycle; returns at the
   // falling edge of the following idle cycle.
   task automatic check_latch(input string tag);
      int n;
      int derr;
      n    = 0;
      derr = 0;
      while (busy === 1'b1 && n < TRST + 20) begin
         if (dout !== 1'b0 || tx_done !== 1'b0) derr++;
         n++;
         @(negedge clk);
      end
      check($sformatf("%s_len", tag), n, TRST);
      check($sformatf("%s_low", tag), derr, 0);
      check($sformatf("%s_idle", tag), {tx_done, dout, busy}, 3'b000);
   endtask

   task automatic wait_txd(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (tx_done === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic hold_idle(input string tag);
      int act;
      act = 0;
      repeat (5) begin
         @(negedge clk);
         if (tx_done !== 1'b0 || busy !== 1'b0 || dout !== 1'b0) act++;
      end
      check(tag, act, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [23:0] w;
      logic        lst;
      bit          ok;
      int          n_txd;

      // Reset held with data_ready high: nothing may start.
      rst        = 1'b1;
      data_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_out", {tx_done, dout, busy}, 3'b000);
      rst = 1'b0;
      @(negedge clk);
      check("first_txd", tx_done, 1'b1);

      // Mixed ones and zeros, then next request exactly one word period later.
      send_word(24'hFF00FF, 1'b0, "w_ff00ff");
      @(negedge clk);
      check("period_txd", tx_done, 1'b1);

      // Five-word frame, last word flagged.
      n_txd = 1;
      for (int i = 0; i < 5; i++) begin
         w = 24'($urandom);
         send_word(w, (i == 4), $sformatf("frame_w%0d", i));
         @(negedge clk);
         if (i < 4 && tx_done === 1'b1) n_txd++;
      end
      check("frame_txd_cnt", n_txd, 5);
      check("frame_latch_start", {busy, dout, tx_done}, 3'b100);
      check_latch("frame_latch");
      @(negedge clk);
      check("b2b_txd", tx_done, 1'b1);

      // Word-order check; data_ready drops during the latch period.
      send_word(24'hAA55C3, 1'b1, "order");
      @(negedge clk);
      check("order_latch_start", {busy, dout, tx_done}, 3'b100);
      data_ready = 1'b0;
      check_latch("order_latch");
      hold_idle("order_idle_hold");

      data_ready = 1'b1;
      wait_txd(5, ok);
      check("resume_txd", ok, 1'b1);
      send_word(24'h800001, 1'b0, "w_800001");
      @(negedge clk);
      check("w800001_next_txd", tx_done, 1'b1);

      // Abort in bit 10, during the high part of the pulse.
      rgb        = 24'($urandom);
      data_valid = 1'b0;
      @(negedge clk);
      repeat (10 * TBIT + 2) @(negedge clk);
      check("abort_pre_high", dout, 1'b1);
      data_ready = 1'b0;
      @(negedge clk);
      check("abort_cut", {busy, dout, tx_done}, 3'b100);
      check_latch("abort_latch");
      hold_idle("abort_idle_hold");

      // Synchronous reset while dout is high.
      data_ready = 1'b1;
      wait_txd(5, ok);
      check("rst_test_txd", ok, 1'b1);
      rgb        = 24'($urandom);
      data_valid = 1'b0;
      @(negedge clk);
      repeat (5 * TBIT + 2) @(negedge clk);
      check("rst_pre_high", dout, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid", {tx_done, dout, busy}, 3'b000);
      rst = 1'b0;
      @(negedge clk);
      check("rst_relaunch", tx_done, 1'b1);

      // Random words with random frame boundaries.
      for (int i = 0; i < 10; i++) begin
         w   = 24'($urandom);
         lst = (i == 9) || ($urandom_range(0, 3) == 0);
         send_word(w, lst, $sformatf("rand_w%0d", i));
         @(negedge clk);
         if (!lst) begin
            check($sformatf("rand_next%0d", i), tx_done, 1'b1);
         end else begin
            check($sformatf("rand_latch_start%0d", i), {busy, dout, tx_done}, 3'b100);
            check_latch($sformatf("rand_latch%0d", i));
            if (i < 9) begin
               @(negedge clk);
               check($sformatf("rand_b2b%0d", i), tx_done, 1'b1);
            end
         end
      end

      data_ready = 1'b0;
      hold_idle("final_idle_hold");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
